// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: bit-time table,
// receiver state encoding and frame-length helper.
package uart_pkg;

  localparam int BT_W = 19;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_t;

  function automatic logic [BT_W-1:0] bit_time(input logic [3:0] baud);
    case (baud)
      4'd0:    bit_time = 19'd333333;
      4'd1:    bit_time = 19'd83333;
      4'd2:    bit_time = 19'd41667;
      4'd3:    bit_time = 19'd20833;
      4'd4:    bit_time = 19'd10417;
      4'd5:    bit_time = 19'd5208;
      4'd6:    bit_time = 19'd2604;
      4'd7:    bit_time = 19'd1736;
      4'd8:    bit_time = 19'd868;
      4'd9:    bit_time = 19'd434;
      4'd10:   bit_time = 19'd217;
      4'd11:   bit_time = 19'd109;
      default: bit_time = 19'd868;
    endcase
  endfunction

  // Total bits on the wire, start and stop included (9..11).
  function automatic logic [3:0] frame_bits(input logic eight, input logic parity_en);
    frame_bits = 4'd9 + {3'd0, eight} + {3'd0, parity_en};
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter producing a one-cycle tick after a half or full bit
// time, then reloading a full bit time for every following tick.
module uart_rx_bit_timer
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            half,
  input  logic [BT_W-1:0] bt,
  output logic            tick
);

  logic [BT_W-1:0] count;
  logic            running;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= (half ? (bt >> 1) : bt) - BT_W'(1);
      running <= 1'b1;
    end else if (tick) begin
      count <= bt - BT_W'(1);
    end else if (running) begin
      count <= count - BT_W'(1);
    end
  end

  assign tick = running && (count == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, recovers start/data/parity/stop frames and
// holds each byte with error flags until the host reads it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx,
  input  logic       read,
  output logic       rxrdy,
  output logic [7:0] rx_data,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  rx_state_t       state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic            rxs;
  logic            tick, tmr_start, tmr_half;
  logic [BT_W-1:0] bt_cfg, bt_sel;
  logic            eight_cfg, pen_cfg, odd_cfg;
  logic [3:0]      payload_bits, bit_idx;
  logic [8:0]      shreg, aligned;
  logic            stop_sample;

  // Synchronizer presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync[SYNC_STAGES-1];

  // The timer is loaded in the same cycle the config is captured, so it takes
  // the live baud selection while idle.
  assign bt_sel = (state == IDLE) ? bit_time(baud) : bt_cfg;

  uart_rx_bit_timer u_timer (
    .clk  (clk),
    .reset(reset),
    .start(tmr_start),
    .half (tmr_half),
    .bt   (bt_sel),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_start = 1'b0;
    tmr_half  = 1'b0;
    unique case (state)
      IDLE: if (!rxs) begin
        state_nxt = START;
        tmr_start = 1'b1;
        tmr_half  = 1'b1;
      end
      START: if (tick) begin
        if (rxs) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
          tmr_start = 1'b1;
        end
      end
      DATA: if (tick && (bit_idx == payload_bits - 4'd1)) state_nxt = STOP;
      STOP: if (tick) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bt_cfg       <= '0;
      eight_cfg    <= 1'b0;
      pen_cfg      <= 1'b0;
      odd_cfg      <= 1'b0;
      payload_bits <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      stop_sample  <= 1'b0;
    end else begin
      if (state == IDLE && !rxs) begin
        bt_cfg       <= bit_time(baud);
        eight_cfg    <= eight;
        pen_cfg      <= parity_en;
        odd_cfg      <= odd_n_even;
        payload_bits <= frame_bits(eight, parity_en) - 4'd2;
      end
      if (state == START && tick) begin
        shreg   <= '0;
        bit_idx <= '0;
      end
      if (state == DATA && tick) begin
        shreg   <= {rxs, shreg[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (state == STOP && tick) stop_sample <= rxs;
    end
  end

  // Data and parity bits entered from the top; shift them down to bit 0.
  assign aligned = shreg >> (4'd9 - payload_bits);

  always_ff @(posedge clk) begin
    if (reset) begin
      rxrdy   <= 1'b0;
      rx_data <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == DONE) begin
      rx_data <= {eight_cfg & aligned[7], aligned[6:0]};
      perr    <= pen_cfg & ((^aligned) ^ odd_cfg);
      ferr    <= ~stop_sample;
      ovf     <= rxrdy & ~read;
      rxrdy   <= 1'b1;
    end else if (read && rxrdy) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table-driven frames plus hand-written
// latency, overrun, glitch and mid-frame reset sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] baud;
  logic       eight, parity_en, odd_n_even;
  logic       rx, read;
  logic       rxrdy;
  logic [7:0] rx_data;
  logic       perr, ferr, ovf;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int fallCyc     = 0;

  typedef struct {
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       odd;
    logic [7:0] data;
    logic       pbit;
    logic       stopb;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
  } vec_t;

  vec_t vecs[10];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud      (baud),
    .eight     (eight),
    .parity_en (parity_en),
    .odd_n_even(odd_n_even),
    .rx        (rx),
    .read      (read),
    .rxrdy     (rxrdy),
    .rx_data   (rx_data),
    .perr      (perr),
    .ferr      (ferr),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int btOf(input logic [3:0] b);
    case (b)
      4'd8:    return 868;
      4'd10:   return 217;
      4'd11:   return 109;
      default: return 868;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    nCompared++;
    if (act < lo || act > hi) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Bit-bangs one frame; each bit lasts bt clocks.
  task automatic sendFrame(input logic [7:0] d, input int nd, input logic pen,
                           input logic pbit, input logic stopb, input int bt);
    @(posedge clk); #1 rx = 1'b0;
    fallCyc = cyc;
    repeat (bt) @(posedge clk);
    for (int i = 0; i < nd; i++) begin
      #1 rx = d[i];
      repeat (bt) @(posedge clk);
    end
    if (pen) begin
      #1 rx = pbit;
      repeat (bt) @(posedge clk);
    end
    #1 rx = stopb;
    repeat (bt) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    baud       = v.baud;
    eight      = v.eight;
    parity_en  = v.pen;
    odd_n_even = v.odd;
    sendFrame(v.data, v.eight ? 8 : 7, v.pen, v.pbit, v.stopb, btOf(v.baud));
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseRead();
    @(posedge clk); #1 read = 1'b1;
    @(posedge clk); #1 read = 1'b0;
  endtask

  task automatic checkCleared(input string tag, input logic [7:0] heldData);
    checkOutput({tag, " rxrdy cleared"}, rxrdy, 0);
    checkOutput({tag, " perr cleared"}, perr, 0);
    checkOutput({tag, " ferr cleared"}, ferr, 0);
    checkOutput({tag, " ovf cleared"}, ovf, 0);
    checkOutput({tag, " data held"}, rx_data, heldData);
  endtask

  initial begin
    int riseCyc;
    bit seen;

    vecs[0] = '{4'd11, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{4'd11, 1'b0, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0};
    vecs[2] = '{4'd11, 1'b0, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0};
    vecs[3] = '{4'd11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{4'd11, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{4'd11, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[6] = '{4'd11, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{4'd10, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8] = '{4'd11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{4'd11, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b0};

    reset = 1'b1; rx = 1'b1; read = 1'b0;
    baud = 4'd8; eight = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset rxrdy", rxrdy, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset perr", perr, 0);
    checkOutput("reset ferr", ferr, 0);
    checkOutput("reset ovf", ovf, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] latency frame at 868 clocks/bit");
    seen = 0;
    riseCyc = 0;
    fork
      sendFrame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 868);
      begin
        for (int k = 0; k < 12000 && !seen; k++) begin
          @(negedge clk);
          if (rxrdy) begin
            seen = 1;
            riseCyc = cyc;
          end
        end
      end
    join
    checkOutput("latency rxrdy seen", seen, 1);
    checkRange("latency cycles", riseCyc - fallCyc - 1, 8249, 8251);
    checkOutput("latency data", rx_data, 8'hA5);
    checkOutput("latency perr", perr, 0);
    checkOutput("latency ferr", ferr, 0);
    checkOutput("latency ovf", ovf, 0);
    pulseRead();
    checkCleared("latency", 8'hA5);
    repeat (868) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d rxrdy", i), rxrdy, 1);
      checkOutput($sformatf("v%0d data", i), rx_data, vecs[i].expData);
      checkOutput($sformatf("v%0d perr", i), perr, vecs[i].expPerr);
      checkOutput($sformatf("v%0d ferr", i), ferr, vecs[i].expFerr);
      checkOutput($sformatf("v%0d ovf", i), ovf, 0);
      pulseRead();
      checkCleared($sformatf("v%0d", i), vecs[i].expData);
      repeat (2 * btOf(vecs[i].baud)) @(posedge clk);
    end

    $display("[TB] overrun sequences");
    baud = 4'd11; eight = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    sendFrame(8'h11, 8, 1'b0, 1'b0, 1'b1, 109);
    repeat (3) @(negedge clk);
    checkOutput("ovr first data", rx_data, 8'h11);
    sendFrame(8'h22, 8, 1'b0, 1'b0, 1'b1, 109);
    repeat (3) @(negedge clk);
    checkOutput("ovr second data", rx_data, 8'h22);
    checkOutput("ovr ovf set", ovf, 1);
    checkOutput("ovr rxrdy", rxrdy, 1);
    pulseRead();
    checkOutput("ovr ovf cleared", ovf, 0);
    sendFrame(8'h33, 8, 1'b0, 1'b0, 1'b1, 109);
    repeat (3) @(negedge clk);
    checkOutput("pre-race rxrdy", rxrdy, 1);
    // Read lands in the DONE cycle: 4 + HB + (N-1)*BT edges after the fall's edge.
    fork
      sendFrame(8'h44, 8, 1'b0, 1'b0, 1'b1, 109);
      begin
        repeat (4 + 54 + 9 * 109) @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    checkOutput("race data", rx_data, 8'h44);
    checkOutput("race rxrdy", rxrdy, 1);
    checkOutput("race ovf", ovf, 0);
    pulseRead();
    repeat (218) @(posedge clk);

    $display("[TB] glitch while idle");
    @(posedge clk); #1 rx = 1'b0;
    repeat (33) @(posedge clk);
    #1 rx = 1'b1;
    repeat (218) @(negedge clk);
    checkOutput("glitch rxrdy", rxrdy, 0);
    sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 109);
    repeat (3) @(negedge clk);
    checkOutput("post-glitch rxrdy", rxrdy, 1);
    checkOutput("post-glitch data", rx_data, 8'h5A);
    checkOutput("post-glitch ferr", ferr, 0);

    $display("[TB] reset in the middle of a frame");
    repeat (218) @(posedge clk);
    sendFrame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 109);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset ovf", ovf, 1);
    repeat (218) @(posedge clk);
    @(posedge clk); #1 rx = 1'b0;
    repeat (109) @(posedge clk);
    #1 rx = 1'b1;
    repeat (163) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset rxrdy", rxrdy, 0);
    checkOutput("midreset rx_data", rx_data, 0);
    checkOutput("midreset ferr", ferr, 0);
    checkOutput("midreset ovf", ovf, 0);
    reset = 1'b0;
    repeat (900) @(negedge clk);
    checkOutput("midreset no partial", rxrdy, 0);
    sendFrame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 109);
    repeat (3) @(negedge clk);
    checkOutput("after-reset rxrdy", rxrdy, 1);
    checkOutput("after-reset data", rx_data, 8'hC3);
    checkOutput("after-reset ferr", ferr, 0);
    checkOutput("after-reset ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
